// File: rtl/sort_2in1_pkg.sv
// Shared constants for the sort_2in1 top-16 tracker: array depth and sum width.
package sort_2in1_pkg;

  localparam int DEPTH     = 16;
  localparam int SUM_EXTRA = $clog2(DEPTH);

  function automatic int sumWidth(input int w);
    return w + SUM_EXTRA;
  endfunction

endpackage

// File: rtl/sort_2in1_cell.sv
// One slot of the descending top-16 array: computes the slot's next value for a new sample.
module sort_2in1_cell #(
  parameter int W = 12
) (
  input  logic         en,
  input  logic [W-1:0] v,
  input  logic [W-1:0] own,
  input  logic [W-1:0] upper,
  output logic [W-1:0] nxt,
  output logic         gtOwn
);

  logic shiftDown;

  // Strict compares: a sample equal to a retained value lands below it.
  assign gtOwn     = (v > own);
  assign shiftDown = (v > upper);

  always_comb begin
    nxt = own;
    if (en) begin
      if (shiftDown) begin
        nxt = upper;
      end else if (gtOwn) begin
        nxt = v;
      end
    end
  end

endmodule

// File: rtl/sort_2in1.sv
// Streaming top-16 tracker: keeps the 16 largest samples descending, outputs max and registered sum.
// Optional macro SORT_2IN1_MIN_OUT_EN adds the DataMin output (smallest retained value).
module sort_2in1
  import sort_2in1_pkg::*;
#(
  parameter int W = 12
) (
  input  logic               clk,
  input  logic               rst_x,
  input  logic               DataEn,
  input  logic [W-1:0]       DataIn,
`ifdef SORT_2IN1_MIN_OUT_EN
  output logic [W-1:0]       DataMin,
`endif
  output logic [W-1:0]       DataMax,
  output logic [W+SUM_EXTRA-1:0] DataSumOut
);

  localparam int SW = sumWidth(W);

  logic [W-1:0]     rArr_p0   [DEPTH];
  logic [W-1:0]     upperArr  [DEPTH];
  logic [W-1:0]     nxtArr    [DEPTH];
  logic [DEPTH-1:0] gtVec;
  logic             insert;
  logic [SW-1:0]    sumNxt;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : gSlot
      // Slot 0 sees an all-ones neighbour so its shift term can never fire.
      if (i == 0) begin : gTop
        assign upperArr[i] = '1;
      end else begin : gRest
        assign upperArr[i] = rArr_p0[i-1];
      end

      sort_2in1_cell #(.W(W)) uCell (
        .en    (DataEn),
        .v     (DataIn),
        .own   (rArr_p0[i]),
        .upper (upperArr[i]),
        .nxt   (nxtArr[i]),
        .gtOwn (gtVec[i])
      );
    end
  endgenerate

  // Any slot being beaten implies the bottom slot is beaten, so the array changes.
  assign insert = DataEn && (|gtVec);

  // Stage p0: sorted register array
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      for (int k = 0; k < DEPTH; k++) begin
        rArr_p0[k] <= '0;
      end
    end else if (insert) begin
      for (int k = 0; k < DEPTH; k++) begin
        rArr_p0[k] <= nxtArr[k];
      end
    end
  end

  always_comb begin
    sumNxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      sumNxt = sumNxt + SW'(rArr_p0[k]);
    end
  end

  // Stage p1: registered sum of all retained entries
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      DataSumOut <= '0;
    end else begin
      DataSumOut <= sumNxt;
    end
  end

  assign DataMax = rArr_p0[0];

`ifdef SORT_2IN1_MIN_OUT_EN
  assign DataMin = rArr_p0[DEPTH-1];
`endif

endmodule

// File: tb/tb_sort_2in1.sv
// Scoreboard bench for sort_2in1: queue-based top-16 reference model, directed and random stimulus.
module tb_sort_2in1;

  localparam int W  = 12;
  localparam int SW = W + 4;

  logic          clk;
  logic          rst_x;
  logic          DataEn;
  logic [W-1:0]  DataIn;
  logic [W-1:0]  DataMax;
  logic [SW-1:0] DataSumOut;
`ifdef SORT_2IN1_MIN_OUT_EN
  logic [W-1:0]  DataMin;
`endif

  sort_2in1 #(.W(W)) dut (
    .clk        (clk),
    .rst_x      (rst_x),
    .DataEn     (DataEn),
    .DataIn     (DataIn),
`ifdef SORT_2IN1_MIN_OUT_EN
    .DataMin    (DataMin),
`endif
    .DataMax    (DataMax),
    .DataSumOut (DataSumOut)
  );

  typedef struct {
    int unsigned mx;
    int unsigned sm;
    int unsigned mn;
  } expT;

  expT         expQ[$];
  int unsigned mdl[$];
  int          checks = 0;
  int          errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int unsigned mdlSum();
    int unsigned s = 0;
    foreach (mdl[k]) s += mdl[k];
    return s;
  endfunction

  task automatic mdlClear();
    mdl = {};
    repeat (16) mdl.push_back(0);
  endtask

  // Keep the 16 largest: add the sample, order descending, drop the smallest.
  task automatic mdlInsert(input int unsigned v);
    mdl.push_back(v);
    mdl.rsort();
    void'(mdl.pop_back());
  endtask

  task automatic step(input bit en, input int unsigned v);
    expT e;
    int unsigned prevSum;
    @(negedge clk);
    DataEn = en;
    DataIn = v[W-1:0];
    prevSum = mdlSum();
    if (en) mdlInsert(v[W-1:0]);
    e.mx = mdl[0];
    e.sm = prevSum;
    e.mn = mdl[15];
    expQ.push_back(e);
  endtask

  task automatic settle();
    repeat (3) step(1'b0, 0);
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    DataEn = 1'b0;
    rst_x  = 1'b0;
    #1;
    checkVal("asyncRstMax", DataMax, 0);
    checkVal("asyncRstSum", DataSumOut, 0);
    mdlClear();
    expQ = {};
    repeat (2) @(negedge clk);
    rst_x = 1'b1;
  endtask

  // Monitor: one expected response per stimulus cycle, compared after the edge settles.
  initial begin
    expT e;
    forever begin
      @(posedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkVal("sbMax", DataMax, e.mx);
        checkVal("sbSum", DataSumOut, e.sm);
`ifdef SORT_2IN1_MIN_OUT_EN
        checkVal("sbMin", DataMin, e.mn);
`endif
      end
    end
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_x  = 1'b0;
    DataEn = 1'b0;
    DataIn = '0;
    mdlClear();
    #1;
    checkVal("rstMax", DataMax, 0);
    checkVal("rstSum", DataSumOut, 0);
`ifdef SORT_2IN1_MIN_OUT_EN
    checkVal("rstMin", DataMin, 0);
`endif
    repeat (2) @(negedge clk);
    rst_x = 1'b1;

    // All-zero stream keeps outputs at zero
    repeat (40) step(1'b1, 0);
    settle();
    checkVal("zeroMax", DataMax, 0);
    checkVal("zeroSum", DataSumOut, 0);

    // Ascending 1..20
    doReset();
    for (int k = 1; k <= 20; k++) step(1'b1, k);
    settle();
    checkVal("ascMax", DataMax, 20);
    checkVal("ascSum", DataSumOut, 200);

    // Descending 20..1
    doReset();
    for (int k = 20; k >= 1; k--) step(1'b1, k);
    settle();
    checkVal("descMax", DataMax, 20);
    checkVal("descSum", DataSumOut, 200);

    // Ties: equal and smaller samples leave the array alone
    doReset();
    repeat (16) step(1'b1, 100);
    step(1'b1, 100);
    step(1'b1, 50);
    settle();
    checkVal("tieSum", DataSumOut, 1600);
    step(1'b1, 4095);
    settle();
    checkVal("bigMax", DataMax, 4095);
    checkVal("bigSum", DataSumOut, 5595);

    // Full scale: no overflow; DataEn=0 holds
    doReset();
    repeat (16) step(1'b1, 4095);
    settle();
    checkVal("fullSum", DataSumOut, 16'hFFF0);
    doReset();
    for (int k = 1; k <= 5; k++) step(1'b1, k * 10);
    repeat (3) step(1'b0, 4095);
    settle();
    checkVal("holdMax", DataMax, 50);
    checkVal("holdSum", DataSumOut, 150);

    // Random streams with a mid-stream asynchronous reset
    doReset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 1) == 0) step($urandom_range(0, 3) != 0, $urandom_range(0, 15));
      else                           step($urandom_range(0, 3) != 0, $urandom_range(0, 4095));
    end
    doReset();
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 4) != 0, $urandom_range(0, 4095));
    end
    settle();
    checkVal("endMax", DataMax, mdl[0]);
    checkVal("endSum", DataSumOut, mdlSum());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sort_2in1.md
Name: sort_2in1

Overview:
- Streaming top-16 tracker for the sort16Max datapath.
- Each enabled cycle accepts one unsigned sample and keeps the 16 largest values seen since reset, ordered descending in a register array.
- Outputs the current maximum and the sum of all 16 retained values.
- Sits after the sample source, which presents one sample per clock or gates samples with DataEn.

Parameters:
- W, default 12: sample width in bits, unsigned, W >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_x  input  1  asynchronous active-low reset.
- DataEn  input  1  sample valid; DataIn is consumed on each rising clk edge where DataEn=1.
- DataIn  input  W  unsigned sample.
- DataMax  output  W  largest retained value, equal to R[0].
- DataSumOut  output  W+4  registered sum of R[0..15].

Behaviour:
- State: R[0..15], each W bits, kept descending: R[0] >= R[1] >= ... >= R[15].
- Reset (rst_x=0, asynchronous): all R[i]=0, DataSumOut=0, so DataMax=0. Deassertion is synchronised externally; the block needs no extra handling.
- Insert rule, on a clk edge with DataEn=1 and v=DataIn, evaluated in parallel for every i:
  - if i>0 and v > R[i-1]: R[i] <= R[i-1] (shift down);
  - else if v > R[i]: R[i] <= v;
  - else R[i] holds.
  - For i=0 there is no shift term: R[0] <= v if v > R[0].
- Ties: comparison is strict, so a new value equal to retained entries lands below them.
- v <= R[15]: array unchanged; the sample is discarded.
- The old R[15] is dropped whenever an insert occurs.
- DataEn=0: R holds.
- DataMax is combinational from R[0]; no logic after the register. It reflects a sample 1 cycle after its enable edge.
- DataSumOut <= sum of R[0..15], registered every cycle regardless of DataEn. It reflects a sample 2 cycles after its enable edge.
- Sum width W+4 cannot overflow (16 * (2^W - 1) < 2^(W+4)), so no saturation is required.
- Initial zeros act as real entries. With DataIn all 0, the outputs stay 0 indefinitely.
- Reset asserted mid-stream clears everything immediately; no partial state survives.

Optional Feature:
- Macro SORT_2IN1_MIN_OUT_EN.
- When defined: adds output port DataMin (W bits) = R[15], combinational from the register. It resets to 0 with the array.
- When undefined: the port does not exist and there is no extra logic.

Decomposition:
- Package sort_2in1_pkg holds:
  - localparam DEPTH=16 and SUM_EXTRA=4 ($clog2(DEPTH));
  - a function computing the sum width from W.
- One natural sub-module, sort_2in1_cell: one array slot.
  - Inputs: v, en, own value, upper neighbour value (tied to all-ones for slot 0, making the shift term never true).
  - Outputs: next value and a "v > own" flag.
  - The top module instantiates 16 cells via generate and contains the adder tree.

Test Plan:
- Reset, then DataEn=1, DataIn=0 for 40 cycles -> DataMax=0, DataSumOut=0 throughout.
- After reset, present 1,2,...,20 on consecutive cycles -> final R = 20..5, DataMax=20, DataSumOut=200 (2 cycles after the last enable).
- Present 20 down to 1 descending -> R = 20..5, DataMax=20, DataSumOut=200; values 4..1 are discarded.
- Fill with 16 copies of 100, then present 100 and 50 -> array unchanged, DataSumOut=1600. Then present 4095 -> DataMax=4095, DataSumOut=1500+4095=5595.
- Fill all entries with 4095 -> DataSumOut=65520 (16'hFFF0), no overflow. Hold DataEn=0 with DataIn=4095 -> no change.
- Mid-stream, pulse rst_x low asynchronously between edges -> DataMax and DataSumOut go to 0 before the next clk edge. Refill resumes normally after release.
